motor_speed_pi: RTL and testbench
=================================

# motor_speed_pi

Closed-loop speed regulator for one drive motor. Consumes the 16-bit per-window feedback edge count produced by the motor feedback pulse counter and compares it with a target count. It runs a sequential proportional-integral update once per measurement window and drives the motor PWM output through an internal PWM generator. It sits between the feedback counter and the motor driver pin, and takes its target and gains from the control register block.

## Interface
Parameters:
- PWM_PERIOD, 2500 — PWM period in clk cycles (20 kHz at 50 MHz).
- DUTY_W, 12 — duty width; must satisfy 2^DUTY_W ≥ PWM_PERIOD.
- INT_LIM, 65535 — integrator clamp magnitude (±INT_LIM).

Ports:
- clk  in  1  system clock, 50 MHz.
- n_rst  in  1  reset, synchronous, active-low.
- enable  in  1  loop enable; low forces duty 0 and clears the integrator.
- target_cnt  in  16  desired edges per window, unsigned.
- meas_cnt  in  16  measured edges per window, unsigned; comes from the feedback counter output.
- meas_valid  in  1  one-cycle strobe, asserted the cycle after meas_cnt updates.
- kp  in  8  proportional gain, unsigned Q4.4.
- ki  in  8  integral gain, unsigned Q4.4.
- duty  out  DUTY_W  current commanded duty in cycles high per period.
- pwm_out  out  1  motor PWM.
- sat  out  1  last update was clamped (high or low).
- busy  out  1  calculation in progress.

## Operation
- FSM states and transitions:
  - IDLE → CALC_P on meas_valid && enable.
  - CALC_P: err = target_cnt − meas_cnt (17b signed); p = kp·err (25b signed).
  - CALC_I: anti-windup — integ holds if the previous update was saturated high and err>0, or saturated low and err<0. Otherwise integ = clamp(integ+err, ±INT_LIM) (18b signed). Then i = ki·integ (26b signed).
  - SUM: u = (p+i) >>> 4 (27b sum, arithmetic shift). Saturation: u<0 gives duty 0 with sat_lo; u>PWM_PERIOD−1 gives PWM_PERIOD−1 with sat_hi.
  - LOAD: register duty, sat; → IDLE.
- meas_valid while busy is ignored; that sample is dropped.
- enable low in any state: FSM → IDLE, integ=0, duty=0, sat=0, sat_hi/lo=0; pwm_out low from the next cycle.
- PWM: period counter 0..PWM_PERIOD−1 free-running. pwm_out = (pcnt < duty_active). duty_active latches duty only when pcnt wraps to 0, so there are no glitched periods. duty 0 gives constant low.
- Reset values: duty 0, pwm_out 0, sat 0, busy 0, integ 0, pcnt 0, FSM IDLE.

## Timing
- meas_valid in cycle N gives busy high N+1..N+4 and duty/sat updated at N+4 (visible N+5). This covers 4 calculation cycles.
- Duty reaches pwm_out at the next pcnt wrap, at most PWM_PERIOD cycles later.
- Reset mid-calculation aborts the calculation; no partial duty is written.
- Simultaneous meas_valid and enable falling edge: enable wins, no calculation.

## Structure
- Shared package motor_pkg holds:
  - Q4.4 shift constant FRAC = 4.
  - FSM state enum.
  - Default PWM_PERIOD.
- Sub-module pwm_gen (period counter, duty_active latch, compare). It is reusable by the steering servo path.

## Test plan
- Reset, then idle 5000 cycles → duty=0, pwm_out=0, busy=0, sat=0.
- kp=16, ki=0, target=100, meas=40, strobe → duty=60 at N+4. Each full period after the next wrap has pwm_out high exactly 60 of 2500 cycles.
- kp=0, ki=16, target=100, meas=90, three strobes → duty 10, 20, 30.
- Anti-windup:
  - kp=0, ki=16, target=5000, meas=0, three strobes → duty 2499, sat=1 each time.
  - Then target=meas → duty 2499.
  - Then target=meas−3000 → duty=2000, sat=0 (a wound-up integrator would give 2499).
- target=10, meas=200, kp=16 → duty=0, sat=1, pwm_out constant low.
- Strobe during busy is ignored (duty reflects only the first sample). enable low at N+2 → no duty update, duty=0, integ cleared (next kp=0/ki=16 err=10 sample gives duty 10).

Source files
------------

// File: rtl/motor_pkg.sv
// Shared constants and FSM state encoding for the motor speed regulator and its PWM path.
package motor_pkg;

  localparam int unsigned FRAC           = 4;
  localparam int unsigned PWM_PERIOD_DEF = 2500;

  localparam int unsigned ERR_W = 17;
  localparam int unsigned P_W   = 25;
  localparam int unsigned INT_W = 18;
  localparam int unsigned I_W   = 26;
  localparam int unsigned SUM_W = 27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC_P,
    ST_CALC_I,
    ST_SUM,
    ST_LOAD
  } pi_state_e;

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM generator; duty is only picked up at the period wrap so no period is glitched.
module pwm_gen #(
  parameter int unsigned PERIOD = 2500,
  parameter int unsigned DUTY_W = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_out
);

  localparam int unsigned PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PCNT_W-1:0] pcnt;
  logic [PCNT_W-1:0] pcnt_nxt;
  logic [DUTY_W-1:0] duty_active;
  logic [DUTY_W-1:0] duty_active_nxt;
  logic              wrap;

  always_comb begin
    wrap            = (pcnt == PCNT_W'(PERIOD - 1));
    pcnt_nxt        = wrap ? '0 : pcnt + PCNT_W'(1);
    duty_active_nxt = duty_active;
    if (clr) begin
      duty_active_nxt = '0;
    end else if (wrap) begin
      duty_active_nxt = duty;
    end
  end

  // pwm_out is registered against the next counter/duty so it lines up with pcnt.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pcnt        <= '0;
      duty_active <= '0;
      pwm_out     <= 1'b0;
    end else begin
      pcnt        <= pcnt_nxt;
      duty_active <= duty_active_nxt;
      pwm_out     <= (DUTY_W'(pcnt_nxt) < duty_active_nxt);
    end
  end

endmodule

// File: rtl/motor_speed_pi.sv
// Per-window PI speed regulator: sequential P, I (with anti-windup) and sum steps drive a PWM duty.
module motor_speed_pi
  import motor_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = PWM_PERIOD_DEF,
  parameter int unsigned DUTY_W     = 12,
  parameter int unsigned INT_LIM    = 65535
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic [15:0]       target_cnt,
  input  logic [15:0]       meas_cnt,
  input  logic              meas_valid,
  input  logic [7:0]        kp,
  input  logic [7:0]        ki,
  output logic [DUTY_W-1:0] duty,
  output logic              pwm_out,
  output logic              sat,
  output logic              busy
);

  localparam logic signed [INT_W:0]   LIM_P    = (INT_W + 1)'(INT_LIM);
  localparam logic signed [INT_W:0]   LIM_N    = -LIM_P;
  localparam logic signed [SUM_W-1:0] DUTY_MAX = SUM_W'(PWM_PERIOD - 1);

  pi_state_e state_q;
  pi_state_e state_nxt;

  logic signed [ERR_W-1:0] err_q;
  logic signed [P_W-1:0]   p_q;
  logic signed [INT_W-1:0] integ_q;
  logic signed [I_W-1:0]   i_q;
  logic [DUTY_W-1:0]       duty_calc_q;
  logic                    hi_calc_q;
  logic                    lo_calc_q;
  logic                    sat_hi_q;
  logic                    sat_lo_q;

  logic                    do_p;
  logic                    do_i;
  logic                    do_sum;
  logic                    do_load;

  logic signed [ERR_W-1:0] err_c;
  logic signed [P_W:0]     p_full;
  logic signed [INT_W:0]   integ_sum;
  logic signed [INT_W-1:0] integ_c;
  logic signed [I_W:0]     i_full;
  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] u_c;
  logic                    hold_c;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state and per-step datapath enables; a low enable aborts from any state.
  always_comb begin
    state_nxt = state_q;
    do_p      = 1'b0;
    do_i      = 1'b0;
    do_sum    = 1'b0;
    do_load   = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (meas_valid) state_nxt = ST_CALC_P;
      ST_CALC_P: begin do_p    = 1'b1; state_nxt = ST_CALC_I; end
      ST_CALC_I: begin do_i    = 1'b1; state_nxt = ST_SUM;    end
      ST_SUM:    begin do_sum  = 1'b1; state_nxt = ST_LOAD;   end
      ST_LOAD:   begin do_load = 1'b1; state_nxt = ST_IDLE;   end
      default:   state_nxt = ST_IDLE;
    endcase
    if (!enable) begin
      state_nxt = ST_IDLE;
      do_p      = 1'b0;
      do_i      = 1'b0;
      do_sum    = 1'b0;
      do_load   = 1'b0;
    end
  end

  // Arithmetic for each step; the integrator freezes while pushing further into saturation.
  always_comb begin
    err_c     = $signed({1'b0, target_cnt}) - $signed({1'b0, meas_cnt});
    p_full    = $signed({1'b0, kp}) * err_c;
    hold_c    = (sat_hi_q && (err_q > 17'sd0)) || (sat_lo_q && (err_q < 17'sd0));
    integ_sum = (INT_W + 1)'(integ_q) + (INT_W + 1)'(err_q);
    if (integ_sum > LIM_P) begin
      integ_c = INT_W'(LIM_P);
    end else if (integ_sum < LIM_N) begin
      integ_c = INT_W'(LIM_N);
    end else begin
      integ_c = INT_W'(integ_sum);
    end
    if (hold_c) begin
      integ_c = integ_q;
    end
    i_full = $signed({1'b0, ki}) * integ_c;
    sum_c  = SUM_W'(p_q) + SUM_W'(i_q);
    u_c    = sum_c >>> FRAC;
  end

  always_ff @(posedge clk) begin
    if (!n_rst || !enable) begin
      err_q       <= '0;
      p_q         <= '0;
      integ_q     <= '0;
      i_q         <= '0;
      duty_calc_q <= '0;
      hi_calc_q   <= 1'b0;
      lo_calc_q   <= 1'b0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
      duty        <= '0;
      sat         <= 1'b0;
    end else begin
      if (do_p) begin
        err_q <= err_c;
        p_q   <= P_W'(p_full);
      end
      if (do_i) begin
        integ_q <= integ_c;
        i_q     <= I_W'(i_full);
      end
      if (do_sum) begin
        lo_calc_q <= u_c[SUM_W-1];
        hi_calc_q <= !u_c[SUM_W-1] && (u_c > DUTY_MAX);
        if (u_c[SUM_W-1]) begin
          duty_calc_q <= '0;
        end else if (u_c > DUTY_MAX) begin
          duty_calc_q <= DUTY_W'(PWM_PERIOD - 1);
        end else begin
          duty_calc_q <= DUTY_W'(u_c);
        end
      end
      if (do_load) begin
        duty     <= duty_calc_q;
        sat      <= hi_calc_q || lo_calc_q;
        sat_hi_q <= hi_calc_q;
        sat_lo_q <= lo_calc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
    end
  end

  pwm_gen #(
    .PERIOD (PWM_PERIOD),
    .DUTY_W (DUTY_W)
  ) u_pwm (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (!enable),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_motor_speed_pi.sv
// Scoreboard bench for motor_speed_pi: expected duty/sat queued at each strobe, checked when busy drops.
module tb_motor_speed_pi;

  localparam int P = 2500;

  logic        clk;
  logic        n_rst;
  logic        enable;
  logic [15:0] target_cnt;
  logic [15:0] meas_cnt;
  logic        meas_valid;
  logic [7:0]  kp;
  logic [7:0]  ki;
  logic [11:0] duty;
  logic        pwm_out;
  logic        sat;
  logic        busy;

  motor_speed_pi dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (enable),
    .target_cnt (target_cnt),
    .meas_cnt   (meas_cnt),
    .meas_valid (meas_valid),
    .kp         (kp),
    .ki         (ki),
    .duty       (duty),
    .pwm_out    (pwm_out),
    .sat        (sat),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int m_integ = 0;
  bit m_hi    = 0;
  bit m_lo    = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  function automatic void model_clear();
    m_integ = 0;
    m_hi    = 0;
    m_lo    = 0;
  endfunction

  // PI update written directly from the control law with plain integers.
  function automatic exp_t model_step(int tgt, int meas, int gp, int gi);
    exp_t r;
    int err, p, i, u;
    err = tgt - meas;
    p   = gp * err;
    if (!((m_hi && err > 0) || (m_lo && err < 0))) begin
      m_integ = m_integ + err;
      if (m_integ > 65535)  m_integ = 65535;
      if (m_integ < -65535) m_integ = -65535;
    end
    i = gi * m_integ;
    u = (p + i) >>> 4;
    m_hi = 0;
    m_lo = 0;
    if (u < 0) begin
      r.duty = 0;
      m_lo   = 1;
    end else if (u > P - 1) begin
      r.duty = P - 1;
      m_hi   = 1;
    end else begin
      r.duty = u;
    end
    r.sat = (m_hi || m_lo) ? 1 : 0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_strobe(input int tgt, input int meas, input int gp, input int gi);
    target_cnt = 16'(tgt);
    meas_cnt   = 16'(meas);
    kp         = 8'(gp);
    ki         = 8'(gi);
    meas_valid = 1'b1;
    tick();
    meas_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("result_timeout", exp_q.size(), 0);
    tick();
  endtask

  task automatic strobe(input int tgt, input int meas, input int gp, input int gi);
    exp_q.push_back(model_step(tgt, meas, gp, gi));
    drive_strobe(tgt, meas, gp, gi);
    wait_drain();
  endtask

  task automatic enable_clear();
    enable = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic count_high(input int cycles, output int highs);
    highs = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
  endtask

  // Monitor: busy falling means a result (or an aborted one) is on duty/sat.
  bit prev_busy = 0;
  always @(negedge clk) begin
    if (prev_busy && !busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("duty", int'(duty), e.duty);
        chk("sat", int'(sat), e.sat);
      end
    end
    prev_busy = busy;
  end

  initial begin
    int highs;
    exp_t e;
    n_rst      = 1'b0;
    enable     = 1'b0;
    target_cnt = '0;
    meas_cnt   = '0;
    meas_valid = 1'b0;
    kp         = '0;
    ki         = '0;
    repeat (4) tick();
    n_rst  = 1'b1;
    enable = 1'b1;
    repeat (5000) tick();
    chk("idle_duty", int'(duty), 0);
    chk("idle_pwm", int'(pwm_out), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_sat", int'(sat), 0);

    // Proportional only, then verify PWM high time over one full period.
    strobe(100, 40, 16, 0);
    repeat (2600) tick();
    count_high(P, highs);
    chk("pwm_high_60", highs, 60);

    // enable low drops pwm_out immediately and clears the loop.
    enable = 1'b0;
    model_clear();
    tick();
    count_high(P, highs);
    chk("pwm_disabled", highs, 0);
    chk("duty_disabled", int'(duty), 0);
    enable = 1'b1;
    tick();

    // Integral only accumulation.
    for (int k = 0; k < 3; k++) strobe(100, 90, 0, 16);

    // Anti-windup.
    enable_clear();
    for (int k = 0; k < 3; k++) strobe(5000, 0, 0, 16);
    strobe(4000, 4000, 0, 16);
    strobe(1000, 4000, 0, 16);

    // Saturate low.
    enable_clear();
    strobe(10, 200, 16, 0);
    count_high(P + 100, highs);
    chk("pwm_const_low", highs, 0);

    // Strobe while busy is dropped.
    enable_clear();
    exp_q.push_back(model_step(100, 90, 0, 16));
    drive_strobe(100, 90, 0, 16);
    tick();
    drive_strobe(100, 0, 0, 16);
    wait_drain();
    repeat (4) tick();

    // Enable low two cycles into a calculation aborts it.
    e.duty = 0;
    e.sat  = 0;
    exp_q.push_back(e);
    drive_strobe(100, 90, 0, 16);
    tick();
    enable = 1'b0;
    model_clear();
    repeat (3) tick();
    enable = 1'b1;
    wait_drain();
    strobe(100, 90, 0, 16);

    // Reset mid-calculation writes no partial duty.
    exp_q.push_back(e);
    drive_strobe(3000, 0, 16, 16);
    tick();
    n_rst = 1'b0;
    model_clear();
    tick();
    n_rst = 1'b1;
    wait_drain();
    chk("reset_abort_duty", int'(duty), 0);

    // Randomized updates with occasional loop clears.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0) enable_clear();
      if (k % 2 == 0)
        strobe($urandom_range(0, 3000), $urandom_range(0, 3000),
               $urandom_range(0, 40), $urandom_range(0, 40));
      else
        strobe($urandom_range(0, 65535), $urandom_range(0, 65535),
               $urandom_range(0, 255), $urandom_range(0, 255));
    end

    repeat (10) tick();
    chk("pending_results", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
